lock_key_sender: RTL and testbench
==================================

// Module: lock_key_sender
// PURPOSE
//   Transmit side of the serial lock interface: accepts a WIDTH-bit key word
//   via valid/ready, and drives it MSB-first onto the lock's shift/d strobe pair
//   with programmable setup/high/low timing derived from clk. After the last bit
//   it samples the lock's "correct" LED (async, 2-flop synced) and reports match.
//   Sits between the bench or host-side controller and the lock's shift/d/led1 pins.
// PARAMETERS
//   WIDTH          16  key length in bits (lock register width)
//   SETUP_CYCLES    4  clk cycles d is stable, shift low, before each shift rise (>=1)
//   HIGH_CYCLES     4  clk cycles shift is held high per bit (>=1)
//   LOW_CYCLES      4  clk cycles shift low after fall, d still held (hold time) (>=1)
//   SETTLE_CYCLES   8  clk cycles after last bit before lock_ok is sampled (>=3)
// PORTS
//   clk       in   1      system clock; all logic on rising edge
//   rst       in   1      synchronous, active-high reset
//   key       in   WIDTH  key word; key[WIDTH-1] sent first
//   in_valid  in   1      key valid
//   in_ready  out  1      high only in IDLE; transfer when in_valid & in_ready
//   lock_ok   in   1      lock "password correct" LED, asynchronous
//   shift     out  1      strobe to lock; lock samples d on its rising edge
//   d         out  1      serial data to lock
//   busy      out  1      high in any state other than IDLE
//   done      out  1      one-cycle pulse when frame complete
//   match     out  1      synced lock_ok sampled at end of frame; valid with done, held until next done
// BEHAVIOUR
//   - Reset (rst high at a clk edge): state=IDLE, shift=0, d=0, busy=0, done=0,
//     match=0, bit counter=0, sync flops=0. in_ready=0 while rst high, 1 in IDLE.
//   - All outputs registered; shift/d glitch-free.
//   - FSM: IDLE -> SETUP -> HIGH -> LOW -> (SETUP for next bit | SETTLE) -> DONE -> IDLE.
//     IDLE:   in_ready=1; on in_valid latch key into shift reg, go SETUP, bit=0.
//     SETUP:  d=current MSB, shift=0, SETUP_CYCLES cycles.
//     HIGH:   shift=1, d unchanged, HIGH_CYCLES cycles.
//     LOW:    shift=0, d unchanged, LOW_CYCLES cycles; then shift reg <<1, bit+1;
//             if bit was WIDTH-1 go SETTLE else SETUP.
//     SETTLE: shift=0, d=0, SETTLE_CYCLES cycles; last cycle captures synced lock_ok.
//     DONE:   done=1, match updated, one cycle; then IDLE.
//   - Timing: accept at edge T -> d=key[WIDTH-1] from T+1; first shift rise at
//     T+1+SETUP_CYCLES; bit period SETUP+HIGH+LOW; done high in cycle
//     T+1+WIDTH*(SETUP+HIGH+LOW)+SETTLE (defaults: T+201).
//   - Exactly WIDTH rising edges on shift per frame; d never changes while shift=1
//     or within LOW_CYCLES after its fall.
//   - in_valid while busy: ignored, no queuing; key sampled only at acceptance.
//   - lock_ok passes 2-flop synchronizer; only the value at end of SETTLE counts.
//   - Reset mid-frame: shift and d drop to 0 at the reset edge; no further shift
//     rises; no done pulse; match cleared. Partial bits already in lock remain.
//   - Counters sized for max(SETUP,HIGH,LOW,SETTLE) and WIDTH; no wrap inside a frame.
// TESTING
//   1. Lock model, key=16'h39C3 -> 16 shift rises, d seq 0011_1001_1100_0011, done at T+201, match=1.
//   2. Fresh lock model, key=16'h0000 -> done at T+201, match=0; lock_ok stays 0.
//   3. key=16'h8001, monitor -> d=1 only on bits 0 and 15; d stable from 4 cycles
//      before each shift rise until 4 cycles after its fall.
//   4. in_valid held high with changing key during frame -> in_ready=0, second key
//      accepted only in the IDLE cycle after done; no extra shift edges.
//   5. rst pulsed while shift=1 on bit 5 -> shift=0,d=0,busy=0 next cycle, no done,
//      match=0; in_ready=1 first cycle after rst low.
//   6. lock_ok toggled during SETTLE, stable 0 in final 3 cycles -> match=0.

Source files
------------

// File: rtl/lock_key_sender_if.sv
// Host/lock signal bundle for lock_key_sender: key handshake, lock strobe pair and status.
// Handshake: a key transfers on a clk edge where in_valid && in_ready; key must be stable then.
interface lock_key_sender_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] key;
    logic             in_valid;
    logic             in_ready;
    logic             lock_ok;
    logic             shift;
    logic             d;
    logic             busy;
    logic             done;
    logic             match;

    modport master (
        output key, in_valid, lock_ok,
        input  in_ready, shift, d, busy, done, match
    );

    modport slave (
        input  key, in_valid, lock_ok,
        output in_ready, shift, d, busy, done, match
    );
endinterface

// File: rtl/lock_key_sender.sv
// Serialises a key word MSB-first onto the lock's shift/d pins with programmable
// setup/high/low timing, then reports the synchronised lock_ok LED as match.
module lock_key_sender #(
    parameter int WIDTH         = 16,
    parameter int SETUP_CYCLES  = 4,
    parameter int HIGH_CYCLES   = 4,
    parameter int LOW_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    lock_key_sender_if.slave   bus,
    output logic [2:0]         state_dbg
);
    localparam int MAX_AB = (SETUP_CYCLES > HIGH_CYCLES) ? SETUP_CYCLES : HIGH_CYCLES;
    localparam int MAX_CD = (LOW_CYCLES > SETTLE_CYCLES) ? LOW_CYCLES : SETTLE_CYCLES;
    localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAXC);
    localparam int BW     = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] HIGH_LAST   = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] LOW_LAST    = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_HIGH   = 3'd2,
        S_LOW    = 3'd3,
        S_SETTLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             sync1, sync2;
    logic             shift_q, d_q, busy_q, done_q, match_q;
    logic             shift_n, d_n, busy_n, done_n, match_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            shift_q <= 1'b0;
            d_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
            sync1   <= bus.lock_ok;
            sync2   <= sync1;
            shift_q <= shift_n;
            d_q     <= d_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            match_q <= match_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        match_n = match_q;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (bus.in_valid) begin
                    state_n = S_SETUP;
                    shreg_n = bus.key;
                    bit_n   = '0;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_n = S_HIGH;
                    cnt_n   = '0;
                end
            end
            S_HIGH: begin
                if (cnt == HIGH_LAST) begin
                    state_n = S_LOW;
                    cnt_n   = '0;
                end
            end
            S_LOW: begin
                if (cnt == LOW_LAST) begin
                    cnt_n   = '0;
                    shreg_n = shreg << 1;
                    bit_n   = bit_cnt + 1'b1;
                    state_n = (bit_cnt == BIT_LAST) ? S_SETTLE : S_SETUP;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                    match_n = sync2;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Pin values are decoded from the next state so the registered pins never glitch.
    always_comb begin
        shift_n = (state_n == S_HIGH);
        d_n     = 1'b0;
        if (state_n == S_SETUP || state_n == S_HIGH || state_n == S_LOW)
            d_n = shreg_n[WIDTH-1];
        busy_n  = (state_n != S_IDLE);
        done_n  = (state_n == S_DONE);
    end

    assign bus.in_ready = (state == S_IDLE) && !rst;
    assign bus.shift    = shift_q;
    assign bus.d        = d_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.match    = match_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_lock_key_sender.sv
// Bench for lock_key_sender: a behavioural lock, a cycle-indexed waveform model and
// directed plus random frames checked through an expected-vector queue.
module tb_lock_key_sender;
    localparam int W  = 16;
    localparam int S  = 4;
    localparam int H  = 4;
    localparam int LO = 4;
    localparam int SE = 8;
    localparam int P  = S + H + LO;
    localparam int L  = W * P + SE;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   state_dbg;
    logic [W-1:0] secret = '0;
    logic [W-1:0] lock_reg = '0;
    logic         lock_clr = 1'b0;
    logic         lock_mode = 1'b0;
    logic         lock_manual = 1'b0;
    logic         cur_match = 1'b0;
    int           rises = 0;
    int           total = 0;
    int           bad = 0;
    logic [5:0]   exp_q[$];

    lock_key_sender_if #(.WIDTH(W)) bus();

    lock_key_sender #(
        .WIDTH(W), .SETUP_CYCLES(S), .HIGH_CYCLES(H),
        .LOW_CYCLES(LO), .SETTLE_CYCLES(SE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Behavioural lock: shifts d in on each shift rise, LED lit when register equals secret.
    always @(posedge bus.shift or posedge lock_clr) begin
        if (lock_clr) begin
            lock_reg <= '0;
        end else begin
            lock_reg <= {lock_reg[W-2:0], bus.d};
            rises    <= rises + 1;
        end
    end

    assign bus.lock_ok = lock_mode ? lock_manual : (lock_reg == secret);

    function automatic logic [5:0] obs_vec();
        return {bus.shift, bus.d, bus.busy, bus.done, bus.match, bus.in_ready};
    endfunction

    // Expected {shift,d,busy,done,match,in_ready} in cycle k after the accepting edge.
    function automatic logic [5:0] exp_vec(input logic [W-1:0] key, input int k,
                                           input logic pm, input logic nm);
        int bi, ph;
        logic sh, dd;
        if (k <= W * P) begin
            bi = (k - 1) / P;
            ph = (k - 1) % P;
            sh = (ph >= S) && (ph < S + H);
            dd = key[W-1-bi];
            return {sh, dd, 1'b1, 1'b0, pm, 1'b0};
        end else if (k <= L) begin
            return {1'b0, 1'b0, 1'b1, 1'b0, pm, 1'b0};
        end
        return {1'b0, 1'b0, 1'b1, 1'b1, nm, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_lock();
        lock_clr = 1'b1;
        #1;
        lock_clr = 1'b0;
    endtask

    // Starts and ends at a negedge of an idle cycle (unless aborted at cycle abort_k).
    task automatic run_frame(input logic [W-1:0] key, input logic manual,
                             input logic settle_val, input int abort_k, input logic hold);
        logic       nm;
        logic [5:0] e;
        int         r0;
        nm = manual ? settle_val : (key == secret);
        check("idle before accept", 32'(obs_vec()), {26'd0, 4'b0000, cur_match, 1'b1});
        lock_mode   = manual;
        lock_manual = ~settle_val;
        bus.key      = key;
        bus.in_valid = 1'b1;
        for (int k = 1; k <= L + 1; k++) exp_q.push_back(exp_vec(key, k, cur_match, nm));
        r0 = rises;
        @(posedge clk);
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            if (hold) bus.key = W'($urandom);
            else bus.in_valid = 1'b0;
            if (manual && k > W * P && k < L - 3) lock_manual = ~lock_manual;
            else if (manual && k >= L - 3) lock_manual = settle_val;
            e = exp_q.pop_front();
            check($sformatf("frame key=%h k=%0d", key, k), 32'(obs_vec()), 32'(e));
            if (k == abort_k) begin
                exp_q.delete();
                check("rises before abort", rises - r0, (abort_k - 1) / P + 1);
                return;
            end
        end
        check($sformatf("shift rises key=%h", key), rises - r0, W);
        cur_match = nm;
        lock_mode = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] rk;
        int           r0;
        bus.key      = '0;
        bus.in_valid = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        check("reset outputs", 32'(obs_vec()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", 32'(obs_vec()), 32'b000001);

        // Matching key, then all-zero key and sparse key on a fresh lock
        secret = 16'h39C3;
        clear_lock();
        run_frame(16'h39C3, 1'b0, 1'b0, 0, 1'b0);
        check("lock reg after 39C3", 32'(lock_reg), 32'h39C3);
        check("match 39C3", 32'(bus.match), 32'd1);
        clear_lock();
        run_frame(16'h0000, 1'b0, 1'b0, 0, 1'b0);
        check("lock_ok stays low", 32'(bus.lock_ok), 32'd0);
        run_frame(16'h8001, 1'b0, 1'b0, 0, 1'b0);
        check("lock reg after 8001", 32'(lock_reg), 32'h8001);

        // in_valid held with changing key: next key only taken after done
        secret = 16'h1234;
        run_frame(16'h1234, 1'b0, 1'b0, 0, 1'b1);
        run_frame(16'hABCD, 1'b0, 1'b0, 0, 1'b0);
        check("lock reg after back-to-back", 32'(lock_reg), 32'hABCD);

        // lock_ok toggling in settle; only the final stable value counts
        run_frame(16'h5A5A, 1'b1, 1'b0, 0, 1'b0);
        run_frame(16'hA5A5, 1'b1, 1'b1, 0, 1'b0);
        run_frame(16'h0F0F, 1'b1, 1'b0, 0, 1'b0);

        // Reset while shift is high on bit 5
        secret = 16'h5555;
        run_frame(16'h5555, 1'b0, 1'b0, 0, 1'b0);
        run_frame(16'hC3C3, 1'b0, 1'b0, 5 * P + S + 2, 1'b0);
        rst = 1'b1;
        r0  = rises;
        @(negedge clk);
        check("reset mid-frame", 32'(obs_vec()), 32'd0);
        rst = 1'b0;
        cur_match = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle after abort %0d", i), 32'(obs_vec()), 32'b000001);
        end
        check("no rises after abort", rises - r0, 0);

        // Random keys, roughly half of them matching the lock
        for (int n = 0; n < 5; n++) begin
            rk = W'($urandom);
            secret = ($urandom_range(0, 1) == 1) ? rk : W'($urandom);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                check("idle gap", 32'(obs_vec()), {26'd0, 4'b0000, cur_match, 1'b1});
                @(negedge clk);
            end
            run_frame(rk, 1'b0, 1'b0, 0, 1'b0);
            check($sformatf("random lock reg %0d", n), 32'(lock_reg), 32'(rk));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
